// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the fetch queue
package fetch_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int INSTR_W_DEF  = 16;
  localparam int DEPTH_DEF    = 4;
  localparam int PC_INC_DEF   = 2;
  localparam int RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // Queue entry layout at the default widths; fetch_queue re-declares it with its own widths
  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc_next;
    logic                   err;
  } fetch_entry_t;

  // Instruction word carried by error entries
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer with synchronous flush for the fetch queue
module fetch_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Ignore pushes into a full buffer and pops from an empty one
  assign empty    = (count == '0);
  assign do_push  = push && (count != CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the buffer in one cycle
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; stale contents are harmless because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch stage with PC, single-outstanding imem requester and queue (optional FETCH_BYPASS_EN)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int PC_INC   = PC_INC_DEF,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  input  logic                   halt,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic                   imem_done,
  input  logic [INSTR_W-1:0]     imem_rdata,
  input  logic                   imem_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [ADDR_W-1:0]      out_pc_next,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] INC        = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(PC_INC - 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_next;
    logic               err;
  } entry_t;

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              stall_q, stall_nxt;

  logic              misaligned;
  logic              can_issue;
  logic              issue;
  logic              err_push;
  logic              resp_accept;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  entry_t            push_entry;
  entry_t            head_entry;

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Issue gating: IDLE only, redirect wins, credit counts queued entries (nothing in flight in IDLE)
  assign misaligned  = |(pc & ALIGN_MASK);
  assign can_issue   = (state == IDLE) && !rst && !redirect && !halt && !stall_q &&
                       (fifo_count < CW'(DEPTH));
  assign issue       = can_issue && !misaligned;
  assign err_push    = can_issue && misaligned;
  assign resp_accept = (state == WAIT) && imem_done && !redirect;

  assign imem_req  = issue;
  assign imem_addr = pc;
  assign count     = fifo_count;

  // Queue push selection and decode-side outputs, with optional same-cycle bypass
  always_comb begin
    push_entry = '0;
    fifo_push  = 1'b0;
    if (resp_accept) begin
      push_entry = '{instr: imem_rdata, pc_next: addr_q + INC, err: imem_err};
      fifo_push  = 1'b1;
    end else if (err_push) begin
      push_entry = '{instr: INSTR_W'(NOP_INSTR), pc_next: pc + INC, err: 1'b1};
      fifo_push  = 1'b1;
    end

    out_valid   = !fifo_empty;
    out_instr   = head_entry.instr;
    out_pc_next = head_entry.pc_next;
    out_err     = !fifo_empty && head_entry.err;
`ifdef FETCH_BYPASS_EN
    if (resp_accept && fifo_empty && !imem_err) begin
      out_valid   = 1'b1;
      out_instr   = imem_rdata;
      out_pc_next = addr_q + INC;
      out_err     = 1'b0;
      if (out_ready) fifo_push = 1'b0;
    end
`endif
    fifo_pop = out_valid && out_ready && !fifo_empty;
  end

  // Next-state logic: redirect reloads pc and decides whether the outstanding response must be dropped
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = addr_q;
    stall_nxt = stall_q;
    if (redirect) begin
      pc_nxt    = redirect_pc;
      stall_nxt = 1'b0;
      if (state != IDLE) state_nxt = imem_done ? IDLE : DROP;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state_nxt = WAIT;
            pc_nxt    = pc + INC;
            addr_nxt  = pc;
          end else if (err_push) begin
            stall_nxt = 1'b1;
          end
        end
        WAIT:    if (imem_done) state_nxt = IDLE;
        DROP:    if (imem_done) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, PC, latched request address and misalignment stall registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= ADDR_W'(RESET_PC);
      addr_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      addr_q  <= addr_nxt;
      stall_q <= stall_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_rdata;
  logic        imem_err;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc_next;
  logic        out_err;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  // memory model state
  int          mem_lat;
  int          cnt;
  int          nreq;
  int          n0;
  logic        pend;
  logic [15:0] p_addr;
  logic        req_seen;
  logic [15:0] addr_seen;

  fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_done   (imem_done),
    .imem_rdata  (imem_rdata),
    .imem_err    (imem_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc_next (out_pc_next),
    .out_err     (out_err),
    .count       (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample request before the edge, then advance the memory model.
  // Response data for address a is a + 0x1000, delivered mem_lat cycles after the request.
  task automatic step();
    @(negedge clk);
    req_seen  = imem_req;
    addr_seen = imem_addr;
    @(posedge clk);
    #1;
    imem_done = 1'b0;
    imem_err  = 1'b0;
    if (req_seen) begin
      nreq++;
      pend   = 1'b1;
      cnt    = mem_lat;
      p_addr = addr_seen;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_done  = 1'b1;
        imem_rdata = p_addr + 16'h1000;
        pend       = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    imem_done = 1'b0; imem_rdata = '0; imem_err = 1'b0; out_ready = 1'b1;
    mem_lat = 3; cnt = 0; nreq = 0; pend = 1'b0; p_addr = '0;

    // reset state
    step(); step();
    #1;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_err", out_err, 0);
    chk("rst_req", imem_req, 0);

    // sequential fetch, 3-cycle memory
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("seq_req", imem_req, 1);
      chk("seq_addr", imem_addr, 2 * k);
      repeat (3) begin
        step(); #1;
        chk("seq_wait_noreq", imem_req, 0);
      end
      step(); #1;
      chk("seq_valid", out_valid, 1);
      chk("seq_instr", out_instr, 16'h1000 + 2 * k);
      chk("seq_pc_next", out_pc_next, 2 * k + 2);
      chk("seq_count", count, 1);
    end

    // back-pressure fill, 1-cycle memory
    rst = 1'b1; out_ready = 1'b0; mem_lat = 1;
    step(); step();
    rst = 1'b0; nreq = 0;
    #1;
    repeat (12) step();
    #1;
    chk("full_nreq", nreq, 4);
    chk("full_req", imem_req, 0);
    chk("full_count", count, 4);
    chk("full_head", out_instr, 16'h1000);
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_instr", out_instr, 16'h1000 + 2 * k);
      chk("drain_pc_next", out_pc_next, 2 * k + 2);
      if (k == 1) begin
        chk("resume_req", imem_req, 1);
        chk("resume_addr", imem_addr, 16'h0008);
      end
      step(); #1;
    end
    chk("resume_instr", out_instr, 16'h1008);

    // redirect while a request to 0x0004 is in flight
    rst = 1'b1; mem_lat = 3;
    step(); step();
    rst = 1'b0; redirect = 1'b1; redirect_pc = 16'h0004;
    #1;
    chk("redir_idle_noreq", imem_req, 0);
    step();
    redirect = 1'b0;
    #1;
    chk("redir4_addr", imem_addr, 16'h0004);
    step();
    redirect = 1'b1; redirect_pc = 16'h0100;
    #1;
    step();
    redirect = 1'b0;
    #1;
    chk("drop_count", count, 0);
    chk("drop_noreq", imem_req, 0);
    step(); #1;
    chk("drop_done_noreq", imem_req, 0);
    step(); #1;
    chk("drop_valid", out_valid, 0);
    chk("drop_count2", count, 0);
    chk("drop_next_req", imem_req, 1);
    chk("drop_next_addr", imem_addr, 16'h0100);

    // redirect in the same cycle as imem_done
    step(); step(); step();
    redirect = 1'b1; redirect_pc = 16'h0200;
    #1;
    step();
    redirect = 1'b0;
    #1;
    chk("same_valid", out_valid, 0);
    chk("same_count", count, 0);
    chk("same_req", imem_req, 1);
    chk("same_addr", imem_addr, 16'h0200);

    // misaligned redirect
    redirect = 1'b1; redirect_pc = 16'h0101;
    #1;
    step();
    redirect = 1'b0;
    #1;
    chk("mis_noreq", imem_req, 0);
    step(); #1;
    chk("mis_valid", out_valid, 1);
    chk("mis_err", out_err, 1);
    chk("mis_instr", out_instr, 0);
    chk("mis_pc_next", out_pc_next, 16'h0103);
    chk("mis_count", count, 1);
    n0 = nreq;
    repeat (3) begin
      step(); #1;
      chk("mis_stall_noreq", imem_req, 0);
    end
    chk("mis_stall_nreq", nreq, n0);
    chk("mis_stall_count", count, 0);
    redirect = 1'b1; redirect_pc = 16'h0200;
    #1;
    step();
    redirect = 1'b0;
    #1;
    chk("mis_recover_req", imem_req, 1);
    chk("mis_recover_addr", imem_addr, 16'h0200);
    chk("mis_recover_err", out_err, 0);

    // halt with a request in flight
    step();
    halt = 1'b1;
    #1;
    step(); step(); step(); #1;
    chk("halt_valid", out_valid, 1);
    chk("halt_instr", out_instr, 16'h1200);
    chk("halt_pc_next", out_pc_next, 16'h0202);
    chk("halt_noreq", imem_req, 0);
    n0 = nreq;
    repeat (3) begin
      step(); #1;
      chk("halt_hold_noreq", imem_req, 0);
    end
    chk("halt_nreq", nreq, n0);
    halt = 1'b0;
    #1;
    chk("unhalt_req", imem_req, 1);
    chk("unhalt_addr", imem_addr, 16'h0202);

    // reset mid-WAIT
    step();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    #1;
    chk("rstw_valid", out_valid, 0);
    chk("rstw_count", count, 0);
    chk("rstw_req", imem_req, 1);
    chk("rstw_pc", imem_addr, 16'h0000);
    repeat (4) step();
    #1;
    chk("rstw_after_valid", out_valid, 1);
    chk("rstw_after_instr", out_instr, 16'h1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised fetch stage: PC register, variable-latency instruction-memory requester and a DEPTH-entry instruction queue feeding decode over a valid/ready handshake.
- Successor to the single-cycle fetch stage; supports multi-cycle memories and decode back-pressure.
- Redirects from execute flush the queue.
- Sits between the PC-redirect logic in execute and the IF/ID latch.

Parameters:
- ADDR_W, 16, PC and memory address width
- INSTR_W, 16, instruction width
- DEPTH, 4, queue entries (power of two, >= 2)
- PC_INC, 2, sequential PC increment in bytes
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect  in  1  branch/jump taken; load redirect_pc and flush
- redirect_pc  in  ADDR_W  redirect target
- halt  in  1  stop issuing new fetches (level)
- imem_req  out  1  request strobe, one cycle per request
- imem_addr  out  ADDR_W  request address, valid with imem_req
- imem_done  in  1  response valid, single-cycle pulse
- imem_rdata  in  INSTR_W  response instruction
- imem_err  in  1  response error, valid with imem_done
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  INSTR_W  head instruction
- out_pc_next  out  ADDR_W  head PC + PC_INC
- out_err  out  1  head carries a memory or alignment error
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (synchronous): pc=RESET_PC, state=IDLE, queue empty, count=0, imem_req=0, out_valid=0, out_err=0, drop flag cleared. Reset mid-request abandons the response.
- States:
  - IDLE: issue when !halt && (count + inflight) < DEPTH.
  - WAIT: one request outstanding.
  - DROP: outstanding response is to be discarded.
  - Only one request may be outstanding; imem_req is never asserted in WAIT or DROP.
- Issue (IDLE -> WAIT): imem_req=1, imem_addr=pc; pc <= pc + PC_INC (mod 2^ADDR_W, wraps silently).
- Response in WAIT with imem_done:
  - push {imem_rdata, imem_addr_latched + PC_INC, imem_err}; go to IDLE.
  - A new issue can occur in the cycle after the response (no back-to-back issue in the done cycle).
- Misaligned pc (bit 0 set when PC_INC=2):
  - no memory request; push one entry with instr=0 and err=1, then stall issuing until redirect.
- Redirect (highest priority, any state):
  - queue flushed, count <= 0, pc <= redirect_pc.
  - From WAIT without imem_done in the same cycle: go to DROP. From WAIT with imem_done in the same cycle: the response is discarded; go to IDLE.
  - From DROP: stay in DROP.
- DROP: on imem_done the data is discarded; go to IDLE. A redirect during DROP updates pc only.
- Pop: out_valid && out_ready; head advances.
  - Simultaneous push and pop: count unchanged.
  - Credit check makes push into a full queue impossible. Pop on an empty queue is ignored.
- Halt: blocks new issue only. An in-flight response is still enqueued and the queue still drains. Deasserting halt resumes from the current pc.
- Outputs are registered from queue storage; latency from imem_done to out_valid is 1 cycle.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the queue is empty and imem_done arrives unflagged, out_* present the response combinationally in the same cycle. If out_ready is also high, the entry is consumed without being written to the queue (0-cycle latency).
- Undefined: all responses pass through the queue (1-cycle latency).
- Redirect and drop priority are identical in both builds.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, WAIT, DROP}
  - queue entry struct {instr, pc_next, err}
  - default widths
  - NOP/zero-instruction constant
- Sub-module fetch_fifo: parametrised circular buffer with DEPTH entries, synchronous flush, and push/pop/count. The FSM, PC and credit logic remain in fetch_queue.

Test Plan:
- Sequential fetch, 3-cycle memory, out_ready=1, RESET_PC=0: out_instr from addresses 0, 2, 4, 6 in order; out_pc_next = 2, 4, 6, 8; one imem_req per 4 cycles.
- out_ready=0, 1-cycle memory, DEPTH=4: exactly 4 requests issued then imem_req stays 0; count=4. Raise out_ready: all 4 drain in order, then issue resumes at 0x0008.
- Redirect to 0x0100 while a request to 0x0004 is in flight: count=0 next cycle; the 0x0004 response is dropped; next imem_addr=0x0100.
- Redirect in the same cycle as imem_done: response discarded; state=IDLE; following request goes to redirect_pc.
- Redirect to 0x0101: no imem_req; one entry with out_err=1, out_instr=0; no further issue until a redirect to 0x0200.
- Halt asserted with one request in flight: response enqueued; no new imem_req while halt=1. rst asserted mid-WAIT: next cycle pc=RESET_PC, out_valid=0, count=0.
